// File: rtl/booth_seq_ctrl.sv
// -----------------------------------------------------------------------------
// booth_seq_ctrl
//   Sequential radix-2 Booth multiplier controller. It time-shares one external
//   WIDTH-bit ripple-carry adder across WIDTH iterations to form a signed
//   2*WIDTH-bit product. The controller owns A/Q/Q_1/M, the iteration counter
//   and the start/done handshake. The adder is purely combinational: operands
//   are driven and the sum is consumed in the same cycle.
//
//   Optional feature, selected by the macro BOOTH_ZERO_SKIP_EN:
//     When defined, an accepted start with a zero operand goes straight to DONE
//     and yields product=0 one cycle later. When undefined, zero operands take
//     the full WIDTH+1 cycles, and the result is still 0.
//
// Parameters
//   WIDTH  operand width; must match the attached adder width (>= 4)
//   CNT_W  iteration counter width; 2**CNT_W must exceed WIDTH
//
// Ports
//   clk, rst_n      clock and asynchronous active-low reset
//   start           request pulse; sampled only in IDLE
//   multiplicand    signed M, captured on an accepted start
//   multiplier      signed Q, captured on an accepted start
//   busy            high from the cycle after an accepted start until done
//   done            single-cycle pulse; product is valid
//   product         signed result; held until the next accepted start
//   add_a, add_b    adder operands
//   add_cin         adder carry-in
//   add_sum         adder sum (combinational from add_a/add_b/add_cin)
//   add_ovf         adder signed-overflow flag
// -----------------------------------------------------------------------------
module booth_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sum,
    input  logic               add_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 q1_q, q1_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic                 accept;
    logic                 zero_op;
    logic                 sign_bit;

    // The done_q term keeps a start that coincides with the done pulse from
    // being accepted; the next start is taken in the cycle after done.
    assign accept = (state_q == S_IDLE) && start && !done_q;

`ifdef BOOTH_ZERO_SKIP_EN
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_op = 1'b0;
`endif

    // The adder may overflow (e.g. 0 - (-2^(WIDTH-1))); the true sign of the
    // WIDTH+1-bit result is the sum MSB corrected by the overflow flag.
    assign sign_bit = add_sum[WIDTH-1] ^ add_ovf;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------- next-state comb
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = zero_op ? S_DONE : S_ITER;
                end
            end
            S_ITER: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- output comb
    // Adder operands depend on state and registers only, never on start.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == S_ITER) begin
            add_a = a_q;
            case ({q_q[0], q1_q})
                2'b01: add_b = m_q;
                2'b10: begin
                    add_b   = ~m_q;
                    add_cin = 1'b1;
                end
                default: add_b = '0;
            endcase
        end
    end

    // ---------------------------------------------------------- datapath comb
    always_comb begin
        a_d    = a_q;
        q_d    = q_q;
        q1_d   = q1_q;
        m_d    = m_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        prod_d = prod_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    m_d    = multiplicand;
                    // A skipped zero operation reports {A,Q}, so Q is cleared.
                    q_d    = zero_op ? '0 : multiplier;
                    a_d    = '0;
                    q1_d   = 1'b0;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            S_ITER: begin
                // {A,Q,Q_1} <= arithmetic right shift of {sign, sum, Q}.
                a_d   = {sign_bit, add_sum[WIDTH-1:1]};
                q_d   = {add_sum[0], q_q[WIDTH-1:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + CNT_W'(1);
            end
            S_DONE: begin
                done_d = 1'b1;
                prod_d = {a_q, q_q};
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------ datapath regs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            q_q    <= '0;
            q1_q   <= 1'b0;
            m_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            prod_q <= '0;
        end else begin
            a_q    <= a_d;
            q_q    <= q_d;
            q1_q   <= q1_d;
            m_q    <= m_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            prod_q <= prod_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
module tb_booth_seq_ctrl;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   mcand = '0;
    logic [W-1:0]   mplier = '0;
    logic           busy, done;
    logic [2*W-1:0] product;
    logic [W-1:0]   add_a, add_b, add_sum;
    logic           add_cin, add_ovf;

    always #5 clk = ~clk;

    // Behavioural ripple-carry adder with signed-overflow flag.
    assign add_sum = add_a + add_b + {{(W-1){1'b0}}, add_cin};
    assign add_ovf = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);

    booth_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .multiplicand(mcand), .multiplier(mplier),
        .busy(busy), .done(done), .product(product),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_ovf(add_ovf)
    );

    // ------------------------------------------------------------ reference
    function automatic logic [2*W-1:0] exp_prod(input logic [W-1:0] m, input logic [W-1:0] q);
        logic signed [2*W-1:0] a, b;
        a = $signed({{W{m[W-1]}}, m});
        b = $signed({{W{q[W-1]}}, q});
        return a * b;
    endfunction

    // Rising edges from the start-sampling edge until done is visible.
    function automatic int exp_lat(input logic [W-1:0] m, input logic [W-1:0] q);
`ifdef BOOTH_ZERO_SKIP_EN
        if (m == '0 || q == '0) return 1;
`endif
        return W + 1;
    endfunction

    logic           m_active = 1'b0, m_busy = 1'b0, m_done = 1'b0;
    logic [2*W-1:0] m_prod = '0, m_pend = '0;
    int             m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_prod   <= '0;
            m_left   <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_active) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_active <= 1'b0;
                    m_busy   <= 1'b0;
                    m_done   <= 1'b1;
                    m_prod   <= m_pend;
                end
            end else if (start && !m_done) begin
                m_active <= 1'b1;
                m_busy   <= 1'b1;
                m_left   <= exp_lat(mcand, mplier);
                m_pend   <= exp_prod(mcand, mplier);
            end
        end
    end

    int ovf_cnt = 0;
    always @(posedge clk) begin
        if (busy && add_ovf) ovf_cnt <= ovf_cnt + 1;
    end

    // ----------------------------------------------------------- checking
    typedef struct {
        string          nm;
        logic [2*W-1:0] act;
        logic [2*W-1:0] exp;
    } chk_t;

    chk_t dq [0:1023];
    int   dir_wr = 0;
    int   dir_rd = 0;
    int   total = 0;
    int   bad = 0;
    bit   run = 1'b0;

    task automatic post(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        dq[dir_wr] = '{nm, act, exp};
        dir_wr++;
    endtask

    task automatic cmp(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Single compare process: drains the directed checks and compares the
    // DUT against the model on every cycle out of reset.
    initial begin
        forever begin
            @(negedge clk);
            while (dir_rd != dir_wr) begin
                cmp(dq[dir_rd].nm, dq[dir_rd].act, dq[dir_rd].exp);
                dir_rd++;
            end
            if (rst_n && run) begin
                cmp("busy", {63'b0, busy}, {63'b0, m_busy});
                cmp("done", {63'b0, done}, {63'b0, m_done});
                cmp("product", product, m_prod);
                if (!m_busy) begin
                    cmp("idle_add_a", {32'b0, add_a}, 64'd0);
                    cmp("idle_add_b", {32'b0, add_b}, 64'd0);
                    cmp("idle_add_cin", {63'b0, add_cin}, 64'd0);
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic do_op(input string nm, input logic [W-1:0] m, input logic [W-1:0] q,
                         input logic [2*W-1:0] exp, input int sp1, input int sp2,
                         output int n);
        bit got;
        int el;
        el = exp_lat(m, q);
        @(posedge clk); #1;
        post({nm, "_done_1cyc"}, {63'b0, done}, 64'd0);
        start = 1'b1; mcand = m; mplier = q;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            n++;
            got = done;
            start = !got && (n == sp1 || n == sp2);
            if (start) begin
                mcand = $urandom;
                mplier = $urandom;
            end
        end
        start = 1'b0;
        post({nm, "_lat"}, 64'(n), 64'(el));
        post({nm, "_prod"}, product, exp);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n, o0;
        bit seen;
        logic [W-1:0] rm, rq;

        rst_n = 1'b0;
        #12;
        post("rst_busy", {63'b0, busy}, 64'd0);
        post("rst_done", {63'b0, done}, 64'd0);
        post("rst_product", product, 64'd0);
        post("rst_add_a", {32'b0, add_a}, 64'd0);
        post("rst_add_b", {32'b0, add_b}, 64'd0);
        post("rst_add_cin", {63'b0, add_cin}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run = 1'b1;

        do_op("basic", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, 0, n);
        post("basic_lat_lit", 64'(n), 64'd33);
        do_op("neg_pos", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6, 0, 0, n);
        do_op("neg_neg", 32'hFFFF_FFF9, 32'hFFFF_FFFA, 64'h0000_0000_0000_002A, 0, 0, n);

        o0 = ovf_cnt;
        do_op("minmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0, n);
        post("minmin_ovf_seen", {63'b0, (ovf_cnt > o0)}, 64'd1);
        do_op("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 0, n);

        do_op("handshake", 32'd7, 32'd11, 64'd77, 5, 20, n);
        do_op("back2back", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 0, 0, n);

        // Reset in the middle of a 9*9 operation.
        @(posedge clk); #1;
        start = 1'b1; mcand = 32'd9; mplier = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        post("midrst_busy", {63'b0, busy}, 64'd0);
        post("midrst_done", {63'b0, done}, 64'd0);
        post("midrst_product", product, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        post("midrst_no_done", {63'b0, seen}, 64'd0);
        post("midrst_prod_held", product, 64'd0);
        do_op("after_rst", 32'd9, 32'd9, 64'd81, 0, 0, n);

        do_op("zero_m", 32'd0, 32'd12345, 64'd0, 0, 0, n);
`ifdef BOOTH_ZERO_SKIP_EN
        post("zero_m_lat_lit", 64'(n), 64'd1);
`else
        post("zero_m_lat_lit", 64'(n), 64'd33);
`endif
        do_op("zero_q", 32'd5, 32'd0, 64'd0, 0, 0, n);

        for (int i = 0; i < 30; i++) begin
            rm = pick();
            rq = pick();
            do_op("rand", rm, rq, exp_prod(rm, rq),
                  $urandom_range(0, 30), $urandom_range(0, 30), n);
        end

        repeat (4) @(negedge clk);
        for (int k = 0; k < 10 && dir_rd != dir_wr; k++) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
